sync_down_timer: RTL and testbench

//  Loadable synchronous down-counter/timer, the count-down counterpart to our up counter.

---
 rtl/sync_down_timer.sv | 85 ++++++++
 tb/tb_sync_down_timer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sync_down_timer.sv
// Loadable synchronous down-counter with terminal-count pulse, one-shot or auto-reload.
// Priority per edge: load > stop > start > en tick.
module sync_down_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_reload_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [WIDTH-1:0] One  = WIDTH'(1);
    localparam logic [WIDTH-1:0] Zero = '0;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load_i) begin
            reload_d = load_val_i;
            count_d  = load_val_i;
            state_d  = StIdle;
        end else if (stop_i) begin
            // stop also masks a simultaneous start in IDLE/DONE
            if (state_q == StRun) begin
                state_d = StIdle;
            end
        end else if (start_i && (state_q != StRun)) begin
            if (count_q != Zero) begin
                state_d = StRun;
            end else if (reload_q != Zero) begin
                count_d = reload_q;
                state_d = StRun;
            end
        end else if ((state_q == StRun) && en_i) begin
            if (count_q > One) begin
                count_d = count_q - One;
            end else if (count_q == One) begin
                tc_d = 1'b1;
                if (mode_reload_i) begin
                    count_d = reload_q;
                end else begin
                    count_d = Zero;
                    state_d = StDone;
                end
            end
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign busy_o  = (state_q == StRun);
    assign done_o  = (state_q == StDone);

endmodule

// File: tb/tb_sync_down_timer.sv
// Scoreboard bench for sync_down_timer: driver pushes model predictions, monitor pops and compares.
module tb_sync_down_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_i, start_i, stop_i, mode_reload_i, en_i;
    logic [3:0] load_val_i;
    logic [3:0] count_o;
    logic       tc_o, busy_o, done_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int   count;
        logic tc;
        logic busy;
        logic done;
        int   id;
    } exp_t;

    exp_t exp_q[$];
    int   step_id = 0;

    // Reference model: plain integers plus two mode flags.
    int   m_count, m_reload;
    logic m_running, m_expired;

    sync_down_timer #(.WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load_i),
        .load_val_i    (load_val_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .mode_reload_i (mode_reload_i),
        .en_i          (en_i),
        .count_o       (count_o),
        .tc_o          (tc_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int c, input logic t, input logic b,
                         input logic d);
        vectors++;
        if (int'(count_o) != c || tc_o !== t || busy_o !== b || done_o !== d) begin
            miscompares++;
            $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
                     name, count_o, tc_o, busy_o, done_o, c, t, b, d);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_reload = 0; m_running = 1'b0; m_expired = 1'b0;
    endtask

    // One clock of stimulus; the model predicts the outputs after the next rising edge.
    task automatic step(input logic ld, input int lv, input logic st, input logic sp,
                        input logic md, input logic e);
        exp_t x;
        logic tick;
        @(negedge clk);
        load_i = ld; load_val_i = 4'(lv); start_i = st; stop_i = sp;
        mode_reload_i = md; en_i = e;
        tick = m_running && e && !ld && !sp;
        x.tc = 1'b0;
        if (ld) begin
            m_reload = lv; m_count = lv; m_running = 1'b0; m_expired = 1'b0;
        end else if (sp) begin
            m_running = 1'b0;
        end else if (st && !m_running) begin
            if (m_count == 0 && m_reload != 0) m_count = m_reload;
            if (m_count != 0) begin
                m_running = 1'b1; m_expired = 1'b0;
            end
        end else if (tick && m_count > 0) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                x.tc = 1'b1;
                if (md) m_count = m_reload;
                else begin
                    m_running = 1'b0; m_expired = 1'b1;
                end
            end
        end
        x.count = m_count; x.busy = m_running; x.done = m_expired;
        x.id = step_id++;
        exp_q.push_back(x);
    endtask

    task automatic idle_step(); step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic tick_step(input logic md); step(1'b0, 0, 1'b0, 1'b0, md, 1'b1); endtask
    task automatic load_step(input int v); step(1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic start_step(); step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0); endtask

    // Monitor: every cycle is an output beat; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("step%0d", e.id), e.count, e.tc, e.busy, e.done);
            end
        end
    end

    initial begin
        rst = 1'b1;
        load_i = 0; load_val_i = 0; start_i = 0; stop_i = 0; mode_reload_i = 0; en_i = 0;
        model_reset();
        #1;
        check("reset_initial", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-run at count=4
        load_step(6); start_step(); tick_step(0); tick_step(0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_midrun", 0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        load_i = 0; start_i = 0; en_i = 0;
        @(negedge clk);
        rst = 1'b0;

        // One-shot 5 down to 0, then hold in DONE
        load_step(5); start_step();
        repeat (7) tick_step(0);

        // Start from DONE reloads
        start_step(); tick_step(0);

        // Auto-reload period 3
        load_step(3); start_step();
        repeat (9) tick_step(1);

        // en gating
        load_step(6); start_step();
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0, logic'(i % 2 == 0));

        // Max load, full one-shot
        load_step(15); start_step();
        repeat (16) tick_step(0);

        // Pause/resume at count 2
        load_step(4); start_step(); tick_step(0); tick_step(0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_step();
        step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        start_step(); tick_step(0); tick_step(0); idle_step();

        // load 0 then start: no effect
        load_step(0); start_step(); tick_step(0);

        // load 7 during RUN at count 3
        load_step(5); start_step(); tick_step(0); tick_step(0);
        step(1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b1);
        tick_step(0);

        // Start while in RUN still ticks
        start_step(); step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 15) == 0),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) < 7));
        end

        repeat (3) idle_step();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

endmodule
